// File: rtl/aes_req_scheduler.sv
// rtl/aes_req_scheduler.sv - round-robin scheduler sharing one pipelined aes_128 core between two requesters
// Optional per-requester issue counters are built when AES_SCHED_PERF_EN is defined.
module aes_req_scheduler #(
  parameter int LATENCY = 21,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [255:0]       req_state,
  input  logic [255:0]       req_key,
  input  logic [2*TAG_W-1:0] req_tag,
  input  logic               issue_en,
  output logic [127:0]       core_state,
  output logic [127:0]       core_key,
  input  logic [127:0]       core_out,
  output logic [1:0]         res_valid,
  output logic [127:0]       res_data,
  output logic [TAG_W-1:0]   res_tag,
`ifdef AES_SCHED_PERF_EN
  output logic [31:0]        perf_issue0,
  output logic [31:0]        perf_issue1,
`endif
  output logic               busy
);

  logic [1:0]       grant;
  logic             issue;
  logic             gsel;
  logic [TAG_W-1:0] gtag;

  logic rr_q, rr_d;
  logic [127:0] core_state_q, core_state_d;
  logic [127:0] core_key_q, core_key_d;

  // One stage per cycle between issue and return; the last stage lines up with core_out.
  logic [LATENCY:0]            pipe_vld_q, pipe_vld_d;
  logic [LATENCY:0]            pipe_own_q, pipe_own_d;
  logic [LATENCY:0][TAG_W-1:0] pipe_tag_q, pipe_tag_d;

  logic [1:0]       res_valid_q, res_valid_d;
  logic [127:0]     res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  always_comb begin
    grant = 2'b00;
    if (!rst && issue_en) begin
      if (req_valid == 2'b11) begin
        grant = rr_q ? 2'b10 : 2'b01;
      end else begin
        grant = req_valid;
      end
    end
  end

  assign req_ready = grant;
  assign issue     = |grant;
  assign gsel      = grant[1];
  assign gtag      = gsel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

  always_comb begin
    rr_d         = rr_q;
    core_state_d = core_state_q;
    core_key_d   = core_key_q;
    if (issue) begin
      rr_d         = ~gsel;
      core_state_d = gsel ? req_state[255:128] : req_state[127:0];
      core_key_d   = gsel ? req_key[255:128] : req_key[127:0];
    end

    pipe_vld_d = {pipe_vld_q[LATENCY-1:0], issue};
    pipe_own_d = {pipe_own_q[LATENCY-1:0], gsel};
    pipe_tag_d = {pipe_tag_q[LATENCY-1:0], gtag};

    res_valid_d = 2'b00;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    if (pipe_vld_q[LATENCY]) begin
      res_valid_d = pipe_own_q[LATENCY] ? 2'b10 : 2'b01;
      res_data_d  = core_out;
      res_tag_d   = pipe_tag_q[LATENCY];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= 1'b0;
      core_state_q <= '0;
      core_key_q   <= '0;
      pipe_vld_q   <= '0;
      pipe_own_q   <= '0;
      pipe_tag_q   <= '0;
      res_valid_q  <= 2'b00;
      res_data_q   <= '0;
      res_tag_q    <= '0;
    end else begin
      rr_q         <= rr_d;
      core_state_q <= core_state_d;
      core_key_q   <= core_key_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_own_q   <= pipe_own_d;
      pipe_tag_q   <= pipe_tag_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
    end
  end

  assign core_state = core_state_q;
  assign core_key   = core_key_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_tag    = res_tag_q;
  assign busy       = (|pipe_vld_q) | (|res_valid_q);

`ifdef AES_SCHED_PERF_EN
  logic [31:0] perf_issue0_q, perf_issue0_d;
  logic [31:0] perf_issue1_q, perf_issue1_d;

  // Counters saturate rather than wrap so a long soak never reads as a small count.
  always_comb begin
    perf_issue0_d = perf_issue0_q;
    perf_issue1_d = perf_issue1_q;
    if (grant[0] && (perf_issue0_q != 32'hFFFF_FFFF)) perf_issue0_d = perf_issue0_q + 32'd1;
    if (grant[1] && (perf_issue1_q != 32'hFFFF_FFFF)) perf_issue1_d = perf_issue1_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue0_q <= '0;
      perf_issue1_q <= '0;
    end else begin
      perf_issue0_q <= perf_issue0_d;
      perf_issue1_q <= perf_issue1_d;
    end
  end

  assign perf_issue0 = perf_issue0_q;
  assign perf_issue1 = perf_issue1_q;
`endif

endmodule
